// File: rtl/sync_pattern_gen.sv
`default_nettype none
// =============================================================================
// Module   : sync_pattern_gen
// Purpose  : Strobed N-bit word source (counter / LFSR / walking-one / constant)
// Revision : 1.0 - initial release
// =============================================================================
module sync_pattern_gen #(
  parameter int           N     = 8,
  parameter logic [N-1:0] TAPS  = N'(8'hB8),
  parameter int           GAP_W = 4,
  parameter int           CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     seed,
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  output logic [N-1:0]     data_out,
  output logic             stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_sent
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_FIN  = 2'd2;

  localparam logic [1:0] C_MODE_CNT   = 2'd0;
  localparam logic [1:0] C_MODE_LFSR  = 2'd1;
  localparam logic [1:0] C_MODE_WALK  = 2'd2;
  localparam logic [1:0] C_MODE_CONST = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [N-1:0]     data_q,    data_d;
  logic             stb_q,     stb_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [CNT_W-1:0] words_q,   words_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             first_q,   first_d;

  // Shadow copies of the run configuration, captured at launch.
  logic [1:0]       mode_q,    mode_d;
  logic [N-1:0]     seed_q,    seed_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic             emit;
  logic             last_word;
  logic [CNT_W-1:0] words_inc;
  logic [N-1:0]     first_word;
  logic [N-1:0]     next_word;

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= C_IDLE;
      data_q    <= '0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      words_q   <= '0;
      gap_cnt_q <= '0;
      first_q   <= 1'b0;
      mode_q    <= C_MODE_CNT;
      seed_q    <= '0;
      gap_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      words_q   <= words_d;
      gap_cnt_q <= gap_cnt_d;
      first_q   <= first_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word generator
  // ---------------------------------------------------------------------------
  always_comb begin
    first_word = seed_q;
    // A zero seed would lock the LFSR and leave walking-one with nothing to walk.
    if ((seed_q == '0) && ((mode_q == C_MODE_LFSR) || (mode_q == C_MODE_WALK))) begin
      first_word = N'(1);
    end

    case (mode_q)
      C_MODE_CNT:   next_word = data_q + N'(1);
      C_MODE_LFSR:  next_word = {data_q[N-2:0], ^(data_q & TAPS)};
      C_MODE_WALK:  next_word = {data_q[N-2:0], data_q[N-1]};
      C_MODE_CONST: next_word = data_q;
      default:      next_word = data_q;
    endcase
  end

  always_comb begin
    words_inc = words_q + CNT_W'(1);
    emit      = ena && (state_q == C_RUN) && !abort && (gap_cnt_q == '0);
    last_word = (count_q != '0) && (words_inc == count_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        C_IDLE: begin
          if (start) begin
            state_d = C_RUN;
          end
        end
        C_RUN: begin
          if (abort) begin
            state_d = C_IDLE;
          end else if (emit && last_word) begin
            state_d = C_FIN;
          end
        end
        C_FIN:   state_d = C_IDLE;
        default: state_d = C_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d    = data_q;
    stb_d     = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    words_d   = words_q;
    gap_cnt_d = gap_cnt_q;
    first_d   = first_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    gap_d     = gap_q;
    count_d   = count_q;

    if (ena) begin
      case (state_q)
        C_IDLE: begin
          if (start) begin
            mode_d    = mode;
            seed_d    = seed;
            gap_d     = gap;
            count_d   = count;
            words_d   = '0;
            busy_d    = 1'b1;
            gap_cnt_d = '0;
            first_d   = 1'b1;
          end
        end
        C_RUN: begin
          if (abort) begin
            busy_d = 1'b0;
          end else if (emit) begin
            data_d    = first_q ? first_word : next_word;
            stb_d     = 1'b1;
            words_d   = words_inc;
            gap_cnt_d = gap_q;
            first_d   = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        C_FIN: begin
          busy_d = 1'b0;
          done_d = !abort;
        end
        default: begin
          busy_d = 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign stb        = stb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_pattern_gen.sv
`default_nettype none
// =============================================================================
// Module   : tb_sync_pattern_gen
// Purpose  : Directed and randomized bench for sync_pattern_gen
// Revision : 1.0 - initial release
// =============================================================================
module tb_sync_pattern_gen;

  localparam int N      = 8;
  localparam int GAP_W  = 4;
  localparam int CNT_W  = 8;
  localparam int TAPS_I = 'hB8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena   = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode  = 2'd0;
  logic [N-1:0]     seed  = '0;
  logic [GAP_W-1:0] gap   = '0;
  logic [CNT_W-1:0] count = '0;
  logic [N-1:0]     data_out;
  logic             stb;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_sent;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sync_pattern_gen #(
    .N     (N),
    .TAPS  (8'hB8),
    .GAP_W (GAP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .seed       (seed),
    .gap        (gap),
    .count      (count),
    .data_out   (data_out),
    .stb        (stb),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  // Reference model: a run is described by the number of enabled edges since
  // launch; word k appears on enabled edge 1 + k*(gap+1).
  bit         m_active = 0;
  bit         m_fin    = 0;
  int         m_t      = 0;
  int         m_k      = 0;
  int         m_gap    = 0;
  int         m_count  = 0;
  logic [1:0] m_mode   = 2'd0;
  logic [7:0] m_seed   = 8'h00;
  logic [7:0] e_data   = 8'h00;
  logic [7:0] e_words  = 8'h00;
  bit         e_stb    = 0;
  bit         e_busy   = 0;
  bit         e_done   = 0;

  bit         chk_en   = 0;
  int         cyc_cnt  = 0;
  int         done_cnt = 0;
  logic [7:0] stb_log[$];
  int         stb_cyc[$];

  function automatic logic [7:0] first_word(input logic [1:0] md, input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s == 8'h00 && (md == 2'd1 || md == 2'd2)) r = 8'h01;
    return r;
  endfunction

  function automatic logic [7:0] step(input logic [1:0] md, input logic [7:0] d);
    int v;
    int ones;
    logic [7:0] r;
    v    = int'(d);
    ones = 0;
    r    = d;
    case (md)
      2'd0: r = 8'((v + 1) % 256);
      2'd1: begin
        for (int i = 0; i < 8; i++) begin
          if (((v >> i) & 1) == 1 && ((TAPS_I >> i) & 1) == 1) ones++;
        end
        r = 8'(((v * 2) % 256) + (ones % 2));
      end
      2'd2: r = 8'(((v * 2) % 256) + (v / 128));
      default: r = d;
    endcase
    return r;
  endfunction

  // Advance the model using the inputs that the coming rising edge will sample.
  task automatic model_step();
    e_stb  = 0;
    e_done = 0;
    if (!rst_n) begin
      m_active = 0;
      m_fin    = 0;
      e_data   = 8'h00;
      e_busy   = 0;
      e_words  = 8'h00;
    end else if (ena) begin
      if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_fin    = 0;
          m_t      = 0;
          m_k      = 0;
          m_mode   = mode;
          m_seed   = seed;
          m_gap    = int'(gap);
          m_count  = int'(count);
          e_words  = 8'h00;
          e_busy   = 1;
        end
      end else begin
        m_t++;
        if (abort) begin
          m_active = 0;
          e_busy   = 0;
        end else if (m_fin) begin
          m_active = 0;
          e_busy   = 0;
          e_done   = 1;
        end else if ((m_t - 1) % (m_gap + 1) == 0) begin
          e_data  = (m_k == 0) ? first_word(m_mode, m_seed) : step(m_mode, e_data);
          m_k++;
          e_words = e_words + 8'h01;
          e_stb   = 1;
          if (m_count != 0 && m_k == m_count) m_fin = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc_cnt++;
    if (chk_en) begin
      checks++;
      if (data_out === e_data && stb === e_stb && busy === e_busy &&
          done === e_done && words_sent === e_words) begin
        passes++;
      end else begin
        $display("FAIL cycle_compare @%0d: got data=%h stb=%b busy=%b done=%b words=%0d, expected data=%h stb=%b busy=%b done=%b words=%0d",
                 cyc_cnt, data_out, stb, busy, done, words_sent,
                 e_data, e_stb, e_busy, e_done, e_words);
      end
      if (stb === 1'b1) begin
        stb_log.push_back(data_out);
        stb_cyc.push_back(cyc_cnt);
      end
      if (done === 1'b1) done_cnt++;
    end
    model_step();
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    stb_log.delete();
    stb_cyc.delete();
  endtask

  task automatic launch(input logic [1:0] md, input logic [7:0] sd, input int g, input int c);
    mode  = md;
    seed  = sd;
    gap   = GAP_W'(g);
    count = CNT_W'(c);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  int d0;
  int rep;
  int zeros;

  initial begin
    cyc(3);
    rst_n  = 1'b1;
    ena    = 1'b1;
    chk_en = 1'b1;
    chk("reset_data", int'(data_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_words", int'(words_sent), 0);

    // Counter, gap 0, four words
    clear_logs();
    d0 = done_cnt;
    launch(2'd0, 8'h10, 0, 4);
    cyc(7);
    chk("cnt_len", stb_log.size(), 4);
    if (stb_log.size() == 4) begin
      chk("cnt_w0", int'(stb_log[0]), 'h10);
      chk("cnt_w3", int'(stb_log[3]), 'h13);
      chk("cnt_consec", stb_cyc[3] - stb_cyc[0], 3);
    end
    chk("cnt_hold", int'(data_out), 'h13);
    chk("cnt_words", int'(words_sent), 4);
    chk("cnt_done", done_cnt - d0, 1);

    // LFSR, gap 2, three words
    clear_logs();
    launch(2'd1, 8'h80, 2, 3);
    cyc(11);
    chk("lfsr_len", stb_log.size(), 3);
    if (stb_log.size() == 3) begin
      chk("lfsr_w1", int'(stb_log[1]), 'h01);
      chk("lfsr_w2", int'(stb_log[2]), 'h02);
      chk("lfsr_gap", stb_cyc[1] - stb_cyc[0], 3);
    end

    // LFSR continuous: period and no lock-up word
    clear_logs();
    launch(2'd1, 8'h01, 0, 0);
    cyc(262);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
    rep   = -1;
    zeros = 0;
    foreach (stb_log[i]) begin
      if (stb_log[i] == 8'h00) zeros++;
      if (i > 0 && rep < 0 && stb_log[i] == 8'h01) rep = i;
    end
    chk("lfsr_period", rep, 255);
    chk("lfsr_zero", zeros, 0);

    // Walking-one from zero seed, gap 1
    clear_logs();
    d0 = done_cnt;
    launch(2'd2, 8'h00, 1, 9);
    cyc(21);
    chk("walk_len", stb_log.size(), 9);
    if (stb_log.size() == 9) begin
      chk("walk_w0", int'(stb_log[0]), 'h01);
      chk("walk_w7", int'(stb_log[7]), 'h80);
      chk("walk_w8", int'(stb_log[8]), 'h01);
      chk("walk_gap", stb_cyc[8] - stb_cyc[7], 2);
    end
    chk("walk_done", done_cnt - d0, 1);

    // Enable pause in the middle of a gap
    clear_logs();
    launch(2'd0, 8'h20, 3, 3);
    cyc(2);
    ena = 1'b0;
    cyc(5);
    ena = 1'b1;
    cyc(16);
    chk("pause_len", stb_log.size(), 3);
    if (stb_log.size() == 3) begin
      chk("pause_gap", stb_cyc[1] - stb_cyc[0], 9);
      chk("pause_gap2", stb_cyc[2] - stb_cyc[1], 4);
    end

    // Continuous counter wrap, start while busy, abort on an emission edge
    clear_logs();
    d0 = done_cnt;
    launch(2'd0, 8'hFE, 0, 0);
    start = 1'b1;
    seed  = 8'h55;
    mode  = 2'd3;
    cyc();
    start = 1'b0;
    cyc(3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_stb", int'(stb), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_data", int'(data_out), 'h01);
    chk("abort_words", int'(words_sent), 4);
    cyc(3);
    chk("abort_len", stb_log.size(), 4);
    if (stb_log.size() == 4) chk("wrap_w2", int'(stb_log[2]), 'h00);
    chk("abort_nodone", done_cnt - d0, 0);

    // Reset mid-run, then a fresh run
    d0 = done_cnt;
    launch(2'd0, 8'h40, 1, 20);
    cyc(6);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_data", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_words", int'(words_sent), 0);
    clear_logs();
    launch(2'd0, 8'h07, 0, 2);
    cyc(5);
    chk("rerun_len", stb_log.size(), 2);
    if (stb_log.size() == 2) chk("rerun_w1", int'(stb_log[1]), 'h08);
    chk("rerun_done", done_cnt - d0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ena   = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      mode  = 2'($urandom_range(0, 3));
      seed  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      gap   = GAP_W'($urandom_range(0, 3));
      count = CNT_W'($urandom_range(0, 9));
      cyc();
    end
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_pattern_gen.md
Name: sync_pattern_gen

Overview:
Stimulus source for the CDC synchronizer experiment. It generates a programmable sequence of N-bit data words, each marked by a one-cycle strobe, in the launch clock domain. data_out drives the synchronizer's launch-domain data input; stb drives its strobe and pulse inputs. This allows on-chip sequences (counter, LFSR, walking-one) to be pushed through the 2FF, pulse and toggle paths without external switch toggling.

Parameters:
N, 8, data word width (N >= 2)
TAPS, 8'hB8, LFSR feedback mask of width N (default is maximal-length for N=8)
GAP_W, 4, width of the inter-word gap field
CNT_W, 8, width of the word-count field and counter

Ports:
clk  input  1  launch-domain clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
ena  input  1  global enable; low freezes all state
start  input  1  level sampled each cycle; a run begins when start=1 in IDLE
abort  input  1  terminates the current run
mode  input  2  00 counter, 01 LFSR, 10 walking-one, 11 constant
seed  input  N  first word of the run
gap  input  GAP_W  idle cycles between consecutive words
count  input  CNT_W  words per run; 0 = continuous
data_out  output  N  current word (registered)
stb  output  1  one-cycle pulse in the cycle data_out takes a new word
busy  output  1  run in progress
done  output  1  one-cycle pulse after the last word of a finite run
words_sent  output  CNT_W  words emitted in the current or last run

Behaviour:
- Clock and reset: one clock (clk). rst_n is synchronous and active-low; it is sampled only on the clk rising edge.
- Reset values: state=IDLE, data_out=0, stb=0, busy=0, done=0, words_sent=0, gap counter=0. Reset has priority over everything, including mid-run. No done pulse is produced on reset.
- ena=0: no register changes, except that stb and done are forced to 0. A pause mid-run freezes data_out, the gap counter and the state.
- States are IDLE, RUN and FIN. All outputs are registered.
- IDLE, on an edge with ena=1 and start=1:
  - latch mode, seed, gap and count into shadow registers;
  - clear words_sent; set busy=1; move to RUN with emit-pending.
  - Later changes to these inputs have no effect on the active run.
- Word emission (RUN, first edge after start, then every gap+1 edges):
  - data_out <= next word; stb=1 for that cycle; words_sent += 1 (wraps modulo 2^CNT_W);
  - the gap counter loads the latched gap, then decrements once per enabled edge while stb=0;
  - emit when the counter is 0. gap=0 gives stb high on consecutive cycles.
- Word sequence. The first word is seed, except:
  - LFSR or walking-one with seed=0: the first word is 1 (avoids the lock-up state);
  - counter: next = data_out + 1, modulo 2^N;
  - LFSR: next = {data_out[N-2:0], XOR-reduce(data_out & TAPS)};
  - walking-one: rotate left by 1 (MSB wraps to LSB);
  - constant: data_out is held at seed (or 0 if seed=0); stb still pulses.
- Termination:
  - count != 0: the emission edge that makes words_sent == count moves the state to FIN.
  - In FIN, the next enabled edge sets done=1 for one cycle, busy=0 and state=IDLE.
  - busy is therefore high from the cycle after start through the last stb cycle. done is high in the cycle after the last stb cycle.
  - count=0: runs until abort; words_sent wraps freely.
- Abort:
  - abort=1 on an enabled edge in RUN or FIN goes straight to IDLE, with busy=0 and no done pulse.
  - data_out and words_sent keep their values.
  - If abort coincides with an emission edge, abort wins: no stb.
- start while busy is ignored. A start held high at the edge where IDLE is re-entered is not acted on; a new run needs start sampled in IDLE, one cycle later at the earliest.
- data_out is stable whenever stb=0. This meets the synchronizer's rule that data must be stable while it crosses domains.

Test Plan:
1. Counter mode: seed=0x10, gap=0, count=4, start pulse -> stb high for 4 consecutive cycles with data_out=0x10,0x11,0x12,0x13; done=1 in the next cycle; busy then low; data_out holds 0x13; words_sent=4.
2. LFSR mode: seed=0x80, gap=2, count=3 -> words 0x80,0x01,0x02 with stb rising edges 3 cycles apart. Second run with seed=0x01, count=0: the word sequence repeats 0x01 after exactly 255 strobes and never shows 0x00.
3. Walking-one mode: seed=0x00, gap=1, count=9 -> 0x01,0x02,...,0x80,0x01; stb every 2 cycles; done after the 9th strobe.
4. ena dropped for 5 cycles mid-gap (gap=3) -> no stb and no state change during the pause; on resume the remaining gap cycles complete before the next word; total strobe count is unchanged.
5. Counter mode: count=0, seed=0xFE -> 0xFE,0xFF,0x00,0x01 wrap. Then abort asserted on an emission edge -> no stb, busy=0, done never asserts. A start pulse while busy had no effect.
6. rst_n low for 1 cycle mid-run -> all outputs 0 on the next cycle, state IDLE, no done. A new start after reset runs normally.
